// File: rtl/gcd_result_streamer_pkg.sv
// Shared constants, FSM state type and header packing for the XGCD result streamer.
package gcd_result_streamer_pkg;

    localparam int RESULT_W     = 1284;
    localparam int DATA_W       = 64;
    localparam int WORDS_PER_OP = (RESULT_W + DATA_W - 1) / DATA_W;
    localparam int SHIFT_W      = WORDS_PER_OP * DATA_W;
    localparam int FRAME_WORDS  = 1 + 2 * WORDS_PER_OP;
    localparam int POS_W        = $clog2(FRAME_WORDS);

    localparam int SEQ_W   = 16;
    localparam int CYCLE_W = 12;
    localparam int MAGIC_W = 16;

    localparam logic [MAGIC_W-1:0] MAGIC = 16'hC0DE;

    localparam int HDR_MAGIC_LSB = 48;
    localparam int HDR_SEQ_LSB   = 32;
    localparam int HDR_CYCLE_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        SEND_A,
        SEND_B
    } state_t;

    // Header word: tag, frame sequence number and the core cycle count; unused bits stay zero.
    function automatic logic [DATA_W-1:0] make_header(input logic [SEQ_W-1:0]   seq,
                                                      input logic [CYCLE_W-1:0] cycles);
        logic [DATA_W-1:0] word;
        word = '0;
        word[HDR_MAGIC_LSB +: MAGIC_W] = MAGIC;
        word[HDR_SEQ_LSB +: SEQ_W]     = seq;
        word[HDR_CYCLE_LSB +: CYCLE_W] = cycles;
        return word;
    endfunction

endpackage

// File: rtl/gcd_result_streamer_if.sv
// Valid/ready stream carrying the framed XGCD results towards a DMA.
interface gcd_result_streamer_if;
    import gcd_result_streamer_pkg::*;

    logic [DATA_W-1:0] M_TDATA;
    logic              M_TVALID;
    logic              M_TREADY;
    logic              M_TLAST;

    modport master (output M_TDATA, output M_TVALID, output M_TLAST, input M_TREADY);
    modport slave  (input M_TDATA, input M_TVALID, input M_TLAST, output M_TREADY);

endinterface

// File: rtl/gcd_word_shifter.sv
// Shadow register for one Bezout coefficient, drained one stream word at a time.
// Contents are meaningless until the first load, so the register has no reset.
module gcd_word_shifter
    import gcd_result_streamer_pkg::*;
(
    input  logic                CLK,
    input  logic                load,
    input  logic                shift,
    input  logic [RESULT_W-1:0] load_value,
    output logic [DATA_W-1:0]   word0,
    output logic [DATA_W-1:0]   word1
);

    logic [SHIFT_W-1:0] shadow;

    // Load zero-extended coefficient, otherwise drop the lowest word on each shift.
    always_ff @(posedge CLK) begin
        if (load) begin
            shadow <= SHIFT_W'(load_value);
        end else if (shift) begin
            shadow <= shadow >> DATA_W;
        end
    end

    assign word0 = shadow[DATA_W-1:0];
    assign word1 = shadow[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/gcd_result_streamer.sv
// Captures each XGCD result and streams it as a 43-word frame: header, 21 words of a, 21 of b.
module gcd_result_streamer
    import gcd_result_streamer_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ENABLE,
    input  logic                  DONE_PULSE,
    input  logic [RESULT_W-1:0]   BEZOUT_A,
    input  logic [RESULT_W-1:0]   BEZOUT_B,
    input  logic [CYCLE_W-1:0]    CYCLE_COUNT,
    input  logic                  CLR_OVF,
    gcd_result_streamer_if.master stream,
    output logic                  BUSY,
    output logic                  OVERFLOW,
    output logic                  FRAME_DONE,
    output logic [SEQ_W-1:0]      SEQ
);

    state_t            state;
    logic [POS_W-1:0]  pos;
    logic [DATA_W-1:0] tdata_q;
    logic              tvalid_q;
    logic              tlast_q;
    logic              ovf_q;
    logic [SEQ_W-1:0]  seq_q;

    logic              handshake;
    logic              final_hs;
    logic              capture;
    logic              drop;
    logic              shift_a;
    logic              shift_b;
    logic [DATA_W-1:0] a_word0;
    logic [DATA_W-1:0] a_word1;
    logic [DATA_W-1:0] b_word0;
    logic [DATA_W-1:0] b_word1;

    assign handshake = tvalid_q & stream.M_TREADY;
    assign final_hs  = handshake & tlast_q;
    assign capture   = ENABLE & DONE_PULSE & ((state == IDLE) | final_hs);
    assign drop      = ENABLE & DONE_PULSE & (state != IDLE) & ~final_hs;
    assign shift_a   = handshake & (state == SEND_A);
    assign shift_b   = handshake & (state == SEND_B);

    gcd_word_shifter sh_a (
        .CLK        (CLK),
        .load       (capture),
        .shift      (shift_a),
        .load_value (BEZOUT_A),
        .word0      (a_word0),
        .word1      (a_word1)
    );

    gcd_word_shifter sh_b (
        .CLK        (CLK),
        .load       (capture),
        .shift      (shift_b),
        .load_value (BEZOUT_B),
        .word0      (b_word0),
        .word1      (b_word1)
    );

    // Frame FSM with registered stream outputs; the header register doubles as the cycle-count latch.
    // tdata_q is preloaded with the next word on each handshake, so it is word1 of the shifter that follows.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            pos      <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            ovf_q    <= 1'b0;
            seq_q    <= '0;
        end else begin
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (CLR_OVF) begin
                ovf_q <= 1'b0;
            end

            if (capture) begin
                seq_q    <= seq_q + SEQ_W'(1);
                tdata_q  <= make_header(seq_q + SEQ_W'(1), CYCLE_COUNT);
                tvalid_q <= 1'b1;
                tlast_q  <= 1'b0;
                pos      <= '0;
                state    <= HDR;
            end else if (handshake) begin
                pos <= pos + POS_W'(1);
                case (state)
                    HDR: begin
                        tdata_q <= a_word0;
                        state   <= SEND_A;
                    end
                    SEND_A: begin
                        if (pos == POS_W'(WORDS_PER_OP)) begin
                            tdata_q <= b_word0;
                            state   <= SEND_B;
                        end else begin
                            tdata_q <= a_word1;
                        end
                    end
                    SEND_B: begin
                        if (pos == POS_W'(FRAME_WORDS - 1)) begin
                            tdata_q  <= '0;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            tdata_q <= b_word1;
                            tlast_q <= (pos == POS_W'(FRAME_WORDS - 2));
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign stream.M_TDATA  = tdata_q;
    assign stream.M_TVALID = tvalid_q;
    assign stream.M_TLAST  = tlast_q;
    assign BUSY            = (state != IDLE);
    assign OVERFLOW        = ovf_q;
    assign FRAME_DONE      = final_hs;
    assign SEQ             = seq_q;

endmodule

// File: tb/tb_gcd_result_streamer.sv
// Self-checking bench for gcd_result_streamer: random coefficients against a frame-level reference model.
module tb_gcd_result_streamer;

    localparam int COEF_W = 1284;
    localparam int PAD_W  = 1344;
    localparam int NWORDS = 43;

    logic                CLK = 1'b0;
    logic                RESET = 1'b1;
    logic                ENABLE = 1'b0;
    logic                DONE_PULSE = 1'b0;
    logic                CLR_OVF = 1'b0;
    logic [COEF_W-1:0]   BEZOUT_A = '0;
    logic [COEF_W-1:0]   BEZOUT_B = '0;
    logic [11:0]         CYCLE_COUNT = '0;
    logic                BUSY;
    logic                OVERFLOW;
    logic                FRAME_DONE;
    logic [15:0]         SEQ;

    int vectors = 0;
    int miscompares = 0;

    logic [64:0] got_q[$];
    logic [64:0] exp_q[$];
    logic [64:0] got_w;
    int          fd_count = 0;
    int          fd_bad = 0;
    int          stall_bad = 0;
    logic        held = 1'b0;
    logic [63:0] held_data;
    logic        held_last;
    logic [15:0] model_seq;

    gcd_result_streamer_if stream ();

    gcd_result_streamer dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .ENABLE      (ENABLE),
        .DONE_PULSE  (DONE_PULSE),
        .BEZOUT_A    (BEZOUT_A),
        .BEZOUT_B    (BEZOUT_B),
        .CYCLE_COUNT (CYCLE_COUNT),
        .CLR_OVF     (CLR_OVF),
        .stream      (stream),
        .BUSY        (BUSY),
        .OVERFLOW    (OVERFLOW),
        .FRAME_DONE  (FRAME_DONE),
        .SEQ         (SEQ)
    );

    always #5 CLK = ~CLK;

    // Observes the stream between edges: records transfers, FRAME_DONE pulses and stall stability.
    always @(negedge CLK) begin
        if (RESET) begin
            held = 1'b0;
        end else begin
            if (held && (!stream.M_TVALID || stream.M_TDATA !== held_data || stream.M_TLAST !== held_last))
                stall_bad++;
            if (stream.M_TVALID && stream.M_TREADY)
                got_q.push_back({stream.M_TLAST, stream.M_TDATA});
            if (FRAME_DONE)
                fd_count++;
            if (FRAME_DONE !== (stream.M_TVALID & stream.M_TREADY & stream.M_TLAST))
                fd_bad++;
            held      = stream.M_TVALID && !stream.M_TREADY;
            held_data = stream.M_TDATA;
            held_last = stream.M_TLAST;
        end
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [COEF_W-1:0] rand_coef();
        logic [COEF_W-1:0] v;
        for (int i = 0; i < 40; i++) v[i*32 +: 32] = $urandom();
        v[COEF_W-1:1280] = 4'($urandom());
        return v;
    endfunction

    // Reference frame: header, then a and b zero-padded to 21 words each, least significant first.
    function automatic void build_frame(input logic [15:0] seq, input logic [11:0] cyc,
                                        input logic [COEF_W-1:0] a, input logic [COEF_W-1:0] b);
        logic [PAD_W-1:0] pa;
        logic [PAD_W-1:0] pb;
        pa = PAD_W'(a);
        pb = PAD_W'(b);
        exp_q.delete();
        exp_q.push_back({1'b0, 16'hC0DE, seq, 20'h0, cyc});
        for (int k = 0; k < 21; k++) exp_q.push_back({1'b0, pa[k*64 +: 64]});
        for (int k = 0; k < 21; k++) exp_q.push_back({(k == 20) ? 1'b1 : 1'b0, pb[k*64 +: 64]});
    endfunction

    task automatic apply_reset();
        RESET = 1'b1;
        ENABLE = 1'b0;
        DONE_PULSE = 1'b0;
        CLR_OVF = 1'b0;
        stream.M_TREADY = 1'b0;
        repeat (2) cycle();
        RESET = 1'b0;
        cycle();
        got_q.delete();
        fd_count = 0;
        fd_bad = 0;
        stall_bad = 0;
        model_seq = 16'h0;
    endtask

    task automatic pulse_done(input logic [COEF_W-1:0] a, input logic [COEF_W-1:0] b, input logic [11:0] cyc);
        BEZOUT_A = a;
        BEZOUT_B = b;
        CYCLE_COUNT = cyc;
        DONE_PULSE = 1'b1;
        cycle();
        DONE_PULSE = 1'b0;
    endtask

    task automatic drain(input int n, input bit rand_ready, output bit ok);
        int budget;
        budget = 0;
        while (got_q.size() < n && budget < 2000) begin
            stream.M_TREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
            budget++;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        stream.M_TREADY = 1'b0;
        cycle();
        vectors++;
        if ({stream.M_TDATA, stream.M_TVALID, stream.M_TLAST} !== 66'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_stream got=%h expected=0", {stream.M_TDATA, stream.M_TVALID, stream.M_TLAST});
        end
        vectors++;
        if ({BUSY, OVERFLOW, FRAME_DONE} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags got=%b expected=000", {BUSY, OVERFLOW, FRAME_DONE});
        end
        vectors++;
        if (SEQ !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_seq got=%h expected=0000", SEQ);
        end
        apply_reset();
        vectors++;
        if ({stream.M_TVALID, BUSY} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL post_reset_idle got=%b expected=00", {stream.M_TVALID, BUSY});
        end
    endtask

    task automatic test_basic_frame();
        logic [COEF_W-1:0] a;
        logic [COEF_W-1:0] b;
        bit ok;
        apply_reset();
        ENABLE = 1'b1;
        stream.M_TREADY = 1'b1;
        a = '0; a[0] = 1'b1;
        b = '0; b[COEF_W-1] = 1'b1;
        pulse_done(a, b, 12'h123);
        model_seq = model_seq + 16'h1;
        build_frame(model_seq, 12'h123, a, b);
        vectors++;
        if (stream.M_TVALID !== 1'b1 || stream.M_TDATA !== 64'hC0DE_0001_0000_0123) begin
            miscompares++;
            $display("[TB] FAIL basic_header got=%b/%h expected=1/c0de000100000123", stream.M_TVALID, stream.M_TDATA);
        end
        drain(NWORDS, 1'b0, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL basic_drain got=%0d words expected=%0d", got_q.size(), NWORDS);
        end
        for (int k = 0; k < NWORDS; k++) begin
            got_w = (k < got_q.size()) ? got_q[k] : 'x;
            vectors++;
            if (got_w !== exp_q[k]) begin
                miscompares++;
                $display("[TB] FAIL basic_word%0d got=%h expected=%h", k, got_w, exp_q[k]);
            end
        end
        vectors++;
        if (got_q.size() == NWORDS && got_q[42] !== {1'b1, 64'h8}) begin
            miscompares++;
            $display("[TB] FAIL basic_last got=%h expected=1_0000000000000008", got_q[42]);
        end
        vectors++;
        if (fd_count !== 1 || fd_bad !== 0) begin
            miscompares++;
            $display("[TB] FAIL basic_frame_done got count=%0d bad=%0d expected 1/0", fd_count, fd_bad);
        end
        vectors++;
        if (BUSY !== 1'b0 || stream.M_TVALID !== 1'b0 || SEQ !== 16'h1) begin
            miscompares++;
            $display("[TB] FAIL basic_idle got busy=%b valid=%b seq=%h expected 0/0/0001", BUSY, stream.M_TVALID, SEQ);
        end
    endtask

    task automatic test_backpressure();
        logic [COEF_W-1:0] a;
        logic [11:0] cyc;
        bit ok;
        apply_reset();
        ENABLE = 1'b1;
        stream.M_TREADY = 1'b0;
        a = '1;
        cyc = 12'($urandom());
        pulse_done(a, a, cyc);
        model_seq = model_seq + 16'h1;
        build_frame(model_seq, cyc, a, a);
        drain(NWORDS, 1'b1, ok);
        repeat (6) begin
            stream.M_TREADY = 1'($urandom_range(0, 1));
            cycle();
        end
        vectors++;
        if (got_q.size() !== NWORDS) begin
            miscompares++;
            $display("[TB] FAIL bp_count got=%0d expected=%0d", got_q.size(), NWORDS);
        end
        for (int k = 0; k < NWORDS; k++) begin
            got_w = (k < got_q.size()) ? got_q[k] : 'x;
            vectors++;
            if (got_w !== exp_q[k]) begin
                miscompares++;
                $display("[TB] FAIL bp_word%0d got=%h expected=%h", k, got_w, exp_q[k]);
            end
        end
        vectors++;
        if (got_q.size() == NWORDS && (got_q[21][63:0] !== 64'hF || got_q[20][63:0] !== 64'hFFFF_FFFF_FFFF_FFFF)) begin
            miscompares++;
            $display("[TB] FAIL bp_top_word got=%h/%h expected=ffffffffffffffff/f", got_q[20][63:0], got_q[21][63:0]);
        end
        vectors++;
        if (stall_bad !== 0 || fd_bad !== 0) begin
            miscompares++;
            $display("[TB] FAIL bp_stability got stall=%0d fd=%0d expected 0/0", stall_bad, fd_bad);
        end
        vectors++;
        if (SEQ !== 16'h1) begin
            miscompares++;
            $display("[TB] FAIL bp_seq got=%h expected=0001", SEQ);
        end
    endtask

    task automatic test_overflow();
        logic [COEF_W-1:0] a;
        logic [COEF_W-1:0] b;
        logic [11:0] cyc;
        bit ok;
        apply_reset();
        ENABLE = 1'b1;
        a = rand_coef();
        b = rand_coef();
        cyc = 12'($urandom());
        pulse_done(a, b, cyc);
        model_seq = model_seq + 16'h1;
        build_frame(model_seq, cyc, a, b);
        repeat (3) cycle();
        pulse_done(rand_coef(), rand_coef(), 12'($urandom()));
        vectors++;
        if (OVERFLOW !== 1'b1 || SEQ !== model_seq || stream.M_TDATA !== exp_q[0][63:0]) begin
            miscompares++;
            $display("[TB] FAIL ovf_drop got ovf=%b seq=%h hdr=%h expected 1/%h/%h", OVERFLOW, SEQ, stream.M_TDATA, model_seq, exp_q[0][63:0]);
        end
        drain(NWORDS, 1'b1, ok);
        for (int k = 0; k < NWORDS; k++) begin
            got_w = (k < got_q.size()) ? got_q[k] : 'x;
            vectors++;
            if (got_w !== exp_q[k]) begin
                miscompares++;
                $display("[TB] FAIL ovf_word%0d got=%h expected=%h", k, got_w, exp_q[k]);
            end
        end
        vectors++;
        if (OVERFLOW !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ovf_sticky got=%b expected=1", OVERFLOW);
        end
        CLR_OVF = 1'b1;
        cycle();
        CLR_OVF = 1'b0;
        vectors++;
        if (OVERFLOW !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ovf_clear got=%b expected=0", OVERFLOW);
        end
        got_q.delete();
        stream.M_TREADY = 1'b0;
        pulse_done(a, b, cyc);
        model_seq = model_seq + 16'h1;
        cycle();
        CLR_OVF = 1'b1;
        pulse_done(rand_coef(), rand_coef(), 12'($urandom()));
        CLR_OVF = 1'b0;
        vectors++;
        if (OVERFLOW !== 1'b1 || SEQ !== model_seq) begin
            miscompares++;
            $display("[TB] FAIL ovf_set_wins got ovf=%b seq=%h expected 1/%h", OVERFLOW, SEQ, model_seq);
        end
        drain(NWORDS, 1'b0, ok);
        vectors++;
        if (!ok || fd_count !== 2) begin
            miscompares++;
            $display("[TB] FAIL ovf_second_frame got words=%0d done=%0d expected %0d/2", got_q.size(), fd_count, NWORDS);
        end
    endtask

    task automatic test_back_to_back();
        logic [COEF_W-1:0] a;
        logic [COEF_W-1:0] b;
        logic [11:0] cyc;
        logic [64:0] last_exp;
        bit ok;
        apply_reset();
        ENABLE = 1'b1;
        stream.M_TREADY = 1'b1;
        a = rand_coef();
        b = rand_coef();
        cyc = 12'($urandom());
        pulse_done(a, b, cyc);
        model_seq = model_seq + 16'h1;
        build_frame(model_seq, cyc, a, b);
        last_exp = exp_q[42];
        drain(NWORDS - 1, 1'b0, ok);
        a = rand_coef();
        b = rand_coef();
        cyc = 12'($urandom());
        pulse_done(a, b, cyc);
        model_seq = model_seq + 16'h1;
        build_frame(model_seq, cyc, a, b);
        vectors++;
        if (got_q.size() !== NWORDS || got_q[got_q.size()-1] !== last_exp) begin
            miscompares++;
            $display("[TB] FAIL b2b_first_last got words=%0d expected %0d ending %h", got_q.size(), NWORDS, last_exp);
        end
        vectors++;
        if (stream.M_TVALID !== 1'b1 || stream.M_TDATA !== exp_q[0][63:0] || SEQ !== 16'h2) begin
            miscompares++;
            $display("[TB] FAIL b2b_header got=%b/%h seq=%h expected 1/%h/0002", stream.M_TVALID, stream.M_TDATA, SEQ, exp_q[0][63:0]);
        end
        vectors++;
        if (OVERFLOW !== 1'b0 || BUSY !== 1'b1 || fd_count !== 1) begin
            miscompares++;
            $display("[TB] FAIL b2b_flags got ovf=%b busy=%b done=%0d expected 0/1/1", OVERFLOW, BUSY, fd_count);
        end
        got_q.delete();
        drain(NWORDS, 1'b1, ok);
        for (int k = 0; k < NWORDS; k++) begin
            got_w = (k < got_q.size()) ? got_q[k] : 'x;
            vectors++;
            if (got_w !== exp_q[k]) begin
                miscompares++;
                $display("[TB] FAIL b2b_word%0d got=%h expected=%h", k, got_w, exp_q[k]);
            end
        end
    endtask

    task automatic test_enable_reset();
        logic [COEF_W-1:0] a;
        logic [COEF_W-1:0] b;
        logic [11:0] cyc;
        int fd_snap;
        bit ok;
        apply_reset();
        stream.M_TREADY = 1'b1;
        pulse_done(rand_coef(), rand_coef(), 12'($urandom()));
        cycle();
        vectors++;
        if (stream.M_TVALID !== 1'b0 || SEQ !== 16'h0 || OVERFLOW !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL en_ignored got valid=%b seq=%h ovf=%b expected 0/0000/0", stream.M_TVALID, SEQ, OVERFLOW);
        end
        ENABLE = 1'b1;
        pulse_done(rand_coef(), rand_coef(), 12'($urandom()));
        drain(5, 1'b0, ok);
        ENABLE = 1'b0;
        pulse_done(rand_coef(), rand_coef(), 12'($urandom()));
        ENABLE = 1'b1;
        vectors++;
        if (OVERFLOW !== 1'b0 || SEQ !== 16'h1 || BUSY !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL en_busy_pulse got ovf=%b seq=%h busy=%b expected 0/0001/1", OVERFLOW, SEQ, BUSY);
        end
        drain(10, 1'b0, ok);
        fd_snap = fd_count;
        #2 RESET = 1'b1;
        #1;
        vectors++;
        if ({stream.M_TDATA, stream.M_TVALID, stream.M_TLAST, BUSY, OVERFLOW, FRAME_DONE, SEQ} !== 85'h0) begin
            miscompares++;
            $display("[TB] FAIL en_async_reset got data=%h valid=%b busy=%b seq=%h expected all 0", stream.M_TDATA, stream.M_TVALID, BUSY, SEQ);
        end
        repeat (3) cycle();
        RESET = 1'b0;
        cycle();
        vectors++;
        if (fd_count !== fd_snap || stream.M_TVALID !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL en_abort got done=%0d valid=%b expected %0d/0", fd_count, stream.M_TVALID, fd_snap);
        end
        got_q.delete();
        model_seq = 16'h0;
        a = rand_coef();
        b = rand_coef();
        cyc = 12'($urandom());
        pulse_done(a, b, cyc);
        model_seq = model_seq + 16'h1;
        build_frame(model_seq, cyc, a, b);
        drain(NWORDS, 1'b1, ok);
        for (int k = 0; k < NWORDS; k++) begin
            got_w = (k < got_q.size()) ? got_q[k] : 'x;
            vectors++;
            if (got_w !== exp_q[k]) begin
                miscompares++;
                $display("[TB] FAIL en_word%0d got=%h expected=%h", k, got_w, exp_q[k]);
            end
        end
    endtask

    task automatic test_seq_wrap();
        logic [COEF_W-1:0] a;
        logic [COEF_W-1:0] b;
        logic [11:0] cyc;
        bit ok;
        apply_reset();
        ENABLE = 1'b1;
        stream.M_TREADY = 1'b1;
        force dut.seq_q = 16'hFFFF;
        cycle();
        release dut.seq_q;
        cycle();
        model_seq = 16'hFFFF;
        vectors++;
        if (SEQ !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL wrap_preset got=%h expected=ffff", SEQ);
        end
        a = rand_coef();
        b = rand_coef();
        cyc = 12'($urandom());
        pulse_done(a, b, cyc);
        model_seq = model_seq + 16'h1;
        build_frame(model_seq, cyc, a, b);
        vectors++;
        if (stream.M_TDATA[47:32] !== 16'h0000 || SEQ !== 16'h0000 || stream.M_TDATA !== exp_q[0][63:0]) begin
            miscompares++;
            $display("[TB] FAIL wrap_header got=%h seq=%h expected=%h/0000", stream.M_TDATA, SEQ, exp_q[0][63:0]);
        end
        drain(NWORDS, 1'b0, ok);
        vectors++;
        if (!ok || got_q[NWORDS-1] !== exp_q[NWORDS-1]) begin
            miscompares++;
            $display("[TB] FAIL wrap_frame got words=%0d expected %0d ending %h", got_q.size(), NWORDS, exp_q[NWORDS-1]);
        end
    endtask

    initial begin
        $display("[TB] gcd_result_streamer bench start");
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_enable_reset();
        test_seq_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gcd_result_streamer.md
Name: gcd_result_streamer

Overview:
- Downstream consumer of the XGCD core's result.
- On each done pulse it captures bezout_a, bezout_b and the cycle count into shadow registers.
- It then streams them out as a framed sequence of 64-bit words on a valid/ready (AXI-Stream-style) master port, so a DMA can drain results without reading the AXI slave window.
- It sits on the CLK_DIV_8 domain beside the register file and AXI unpacker.

Parameters:
- RESULT_W, 1284, width of each Bezout coefficient.
- DATA_W, 64, stream word width.
- WORDS_PER_OP, ceil(RESULT_W/DATA_W) = 21 (derived, not overridable), words per coefficient.
- MAGIC, 16'hC0DE, header tag.

Ports:
- CLK  in  1  block clock (CLK_DIV_8 domain)
- RESET  in  1  asynchronous, active-high reset
- ENABLE  in  1  capture enable; when 0, DONE_PULSE is ignored
- DONE_PULSE  in  1  single-cycle core completion pulse
- BEZOUT_A  in  RESULT_W  coefficient a; valid in the DONE_PULSE cycle
- BEZOUT_B  in  RESULT_W  coefficient b; valid in the DONE_PULSE cycle
- CYCLE_COUNT  in  12  core cycle count; valid in the DONE_PULSE cycle
- CLR_OVF  in  1  clears OVERFLOW
- M_TDATA  out  DATA_W  stream data
- M_TVALID  out  1  stream valid
- M_TREADY  in  1  stream ready
- M_TLAST  out  1  marks the final word of a frame
- BUSY  out  1  frame in progress
- OVERFLOW  out  1  sticky: a result was dropped while busy
- FRAME_DONE  out  1  one-cycle pulse on the final-word handshake
- SEQ  out  16  count of accepted frames

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. Ports are named CLK and RESET.
- Reset values: M_TDATA=0, M_TVALID=0, M_TLAST=0, BUSY=0, OVERFLOW=0, FRAME_DONE=0, SEQ=0, state=IDLE.
- Reset mid-frame aborts the frame with no FRAME_DONE. Shadow contents are don't-care after reset.
- FSM states: IDLE, HDR, SEND_A, SEND_B.
- Capture condition: ENABLE & DONE_PULSE & (state==IDLE, or the final-word handshake is in this cycle).
- On capture:
  - Load BEZOUT_A and BEZOUT_B, each zero-extended to WORDS_PER_OP*DATA_W = 1344 bits, into shift registers SH_A and SH_B.
  - Latch CYCLE_COUNT.
  - SEQ <= SEQ+1, wrapping 0xFFFF -> 0.
  - Go to HDR.
- Latency: capture at cycle t; M_TVALID=1 with the header at t+1.
- Header word: [63:48]=MAGIC, [47:32]=SEQ value after the increment, [31:12]=0, [11:0]=latched cycle count.
- Handshake: a word transfers when M_TVALID & M_TREADY.
  - M_TDATA and M_TLAST hold stable while M_TVALID & !M_TREADY.
  - M_TVALID never drops mid-frame without a handshake.
  - M_TVALID does not wait on M_TREADY.
- HDR: on handshake go to SEND_A with word index = 0.
- SEND_A:
  - M_TDATA = SH_A[63:0]; each handshake shifts SH_A right by 64 and increments the index.
  - After word 20 is sent, go to SEND_B with the index reset to 0.
- SEND_B:
  - Same scheme on SH_B.
  - Word 20 carries M_TLAST=1.
  - Its handshake pulses FRAME_DONE and returns to IDLE, or re-enters HDR if a capture occurs in the same cycle.
- Frame length: always 43 words (1 header + 21 + 21).
  - Word 20 of each coefficient carries bits [1283:1280] in [3:0]; upper bits are 0.
- BUSY = (state != IDLE).
- Dropped results: DONE_PULSE & ENABLE while busy, and not in a final-handshake cycle, sets OVERFLOW. The result is dropped and SEQ is unchanged.
- Overflow priority: CLR_OVF clears OVERFLOW; a set event in the same cycle wins, so OVERFLOW=1.
- ENABLE=0 affects only capture. An in-flight frame completes normally, and a DONE_PULSE with ENABLE=0 does not set OVERFLOW.

Decomposition:
- Shared package holds:
  - state enum (IDLE/HDR/SEND_A/SEND_B)
  - DATA_W, RESULT_W, WORDS_PER_OP
  - MAGIC
  - frame length constant 43
  - header field offsets
- One natural sub-module: gcd_word_shifter, a loadable 1344-bit right shift-by-DATA_W register with load/shift enables, instantiated twice (SH_A, SH_B). The FSM, counters and flags stay in the top.

Test Plan:
1. Basic frame:
   - Stimulus: reset, ENABLE=1, M_TREADY=1; DONE_PULSE with A=1, B=2^1283, CYCLE_COUNT=0x123.
   - Response:
     - Header 0xC0DE_0001_0000_0123.
     - Word 1 = 1, words 2..21 = 0, words 22..41 = 0.
     - Word 42 = 0x8 with M_TLAST=1.
     - FRAME_DONE on the same cycle; BUSY falls the next cycle.
2. Backpressure:
   - Stimulus: M_TREADY toggled pseudo-randomly; A=B=all-ones.
   - Response: exactly 43 transfers; data stable during stalls; words 1..20 = 0xFFFF_FFFF_FFFF_FFFF and word 21 = 0xF (same pattern for B); SEQ=1.
3. Overflow:
   - Stimulus: second DONE_PULSE mid-frame (M_TREADY=0).
   - Response: OVERFLOW=1, SEQ stays 1, frame content unchanged.
   - Then assert CLR_OVF alone -> OVERFLOW=0. Assert CLR_OVF together with a new drop event -> OVERFLOW stays 1.
4. Back-to-back:
   - Stimulus: DONE_PULSE in the cycle of the final-word handshake.
   - Response: next cycle M_TVALID=1 with a header whose SEQ=2; no idle gap; OVERFLOW=0.
5. Enable/reset:
   - Stimulus: DONE_PULSE with ENABLE=0 -> M_TVALID stays 0, SEQ and OVERFLOW unchanged.
   - Stimulus: RESET asserted at word 10 -> all outputs 0 immediately, no FRAME_DONE.
   - Stimulus: after release, a new DONE_PULSE -> header SEQ=1.
6. SEQ wrap:
   - Stimulus: force SEQ=0xFFFF, then capture.
   - Response: header [47:32]=0x0000, SEQ=0.
